ff_bank_ctrl: RTL and testbench



---
 rtl/ff_bank_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_ff_bank_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ff_bank_ctrl.sv
// ============================================================================
// Module   : ff_bank_ctrl
// Summary  : JK flip-flop bank controller for manual and auto-pattern modes.
//            Optional input synchronizers: define FF_BANK_SYNC_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ff_bank_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int DIV_W = 26
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mode,
  input  logic                       btn_step,
  input  logic                       btn_run,
  input  logic [WIDTH-1:0]           sw_j,
  input  logic [WIDTH-1:0]           sw_k,
  output logic [WIDTH-1:0]           q,
  output logic [$clog2(DEPTH)-1:0]   step_idx,
  output logic                       running,
  output logic                       tick
);

  localparam int c_idx_w = $clog2(DEPTH);
  localparam logic [DIV_W-1:0] c_div_pre = {DIV_W{1'b1}} - DIV_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  logic             w_mode;
  logic             w_btn_step;
  logic             w_btn_run;
  logic [WIDTH-1:0] w_sw_j;
  logic [WIDTH-1:0] w_sw_k;

`ifdef FF_BANK_SYNC_EN
  logic [1:0]       r_mode_sync;
  logic [1:0]       r_step_sync;
  logic [1:0]       r_run_sync;
  logic [WIDTH-1:0] r_j_sync1;
  logic [WIDTH-1:0] r_j_sync2;
  logic [WIDTH-1:0] r_k_sync1;
  logic [WIDTH-1:0] r_k_sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode_sync <= '0;
      r_step_sync <= '0;
      r_run_sync  <= '0;
      r_j_sync1   <= '0;
      r_j_sync2   <= '0;
      r_k_sync1   <= '0;
      r_k_sync2   <= '0;
    end else begin
      r_mode_sync <= {r_mode_sync[0], mode};
      r_step_sync <= {r_step_sync[0], btn_step};
      r_run_sync  <= {r_run_sync[0], btn_run};
      r_j_sync1   <= sw_j;
      r_j_sync2   <= r_j_sync1;
      r_k_sync1   <= sw_k;
      r_k_sync2   <= r_k_sync1;
    end
  end

  assign w_mode     = r_mode_sync[1];
  assign w_btn_step = r_step_sync[1];
  assign w_btn_run  = r_run_sync[1];
  assign w_sw_j     = r_j_sync2;
  assign w_sw_k     = r_k_sync2;
`else
  assign w_mode     = mode;
  assign w_btn_step = btn_step;
  assign w_btn_run  = btn_run;
  assign w_sw_j     = sw_j;
  assign w_sw_k     = sw_k;
`endif

  // Buttons are sampled once before edge detection, so an action lands one
  // edge after the button is first seen.
  logic r_step_smp;
  logic r_step_prev;
  logic r_run_smp;
  logic r_run_prev;
  logic w_step_rise;
  logic w_run_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_step_smp  <= 1'b0;
      r_step_prev <= 1'b0;
      r_run_smp   <= 1'b0;
      r_run_prev  <= 1'b0;
    end else begin
      r_step_smp  <= w_btn_step;
      r_step_prev <= r_step_smp;
      r_run_smp   <= w_btn_run;
      r_run_prev  <= r_run_smp;
    end
  end

  assign w_step_rise = r_step_smp & ~r_step_prev;
  assign w_run_rise  = r_run_smp & ~r_run_prev;

  logic [DIV_W-1:0] r_div;
  logic             r_tick;

  // tick is registered one count early so it is high while the count is all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_div  <= r_div + DIV_W'(1);
      r_tick <= (r_div == c_div_pre);
    end
  end

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_q;
  logic [c_idx_w-1:0] r_step_idx;
  logic [c_idx_w-1:0] w_idx_next;
  logic               r_running;
  logic               w_apply;
  logic               w_use_pat;
  logic [WIDTH-1:0]   w_pat_j;
  logic [WIDTH-1:0]   w_pat_k;
  logic [WIDTH-1:0]   w_cmd_j;
  logic [WIDTH-1:0]   w_cmd_k;
  logic [WIDTH-1:0]   w_q_cmd;

  assign w_cmd_j = w_use_pat ? w_pat_j : w_sw_j;
  assign w_cmd_k = w_use_pat ? w_pat_k : w_sw_k;

  // Pattern command code (s+i) mod 4 coincides with the {j,k} encoding.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      localparam logic [1:0] c_off = 2'(gi);
      assign {w_pat_j[gi], w_pat_k[gi]} = r_step_idx[1:0] + c_off;
      assign w_q_cmd[gi] = w_cmd_j[gi] ? (w_cmd_k[gi] ? ~r_q[gi] : 1'b1)
                                       : (w_cmd_k[gi] ? 1'b0 : r_q[gi]);
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_apply      = 1'b0;
    w_use_pat    = 1'b0;
    w_idx_next   = r_step_idx;
    case (r_state)
      S_IDLE: begin
        if (w_step_rise) begin
          w_apply = 1'b1;
        end
        if (w_mode && w_run_rise) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (!w_mode) begin
          w_state_next = S_IDLE;
          w_idx_next   = '0;
        end else begin
          if (r_tick) begin
            w_apply    = 1'b1;
            w_use_pat  = 1'b1;
            w_idx_next = r_step_idx + c_idx_w'(1);
          end
          if (w_run_rise) begin
            w_state_next = S_PAUSE;
          end
        end
      end
      S_PAUSE: begin
        if (!w_mode) begin
          w_state_next = S_IDLE;
          w_idx_next   = '0;
        end else if (w_run_rise) begin
          w_state_next = S_RUN;
        end else if (w_step_rise) begin
          w_apply    = 1'b1;
          w_use_pat  = 1'b1;
          w_idx_next = r_step_idx + c_idx_w'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_q        <= '0;
      r_step_idx <= '0;
      r_running  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_step_idx <= w_idx_next;
      r_running  <= (w_state_next == S_RUN);
      if (w_apply) begin
        r_q <= w_q_cmd;
      end
    end
  end

  assign q        = r_q;
  assign step_idx = r_step_idx;
  assign running  = r_running;
  assign tick     = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_ff_bank_ctrl.sv
// ============================================================================
// Module   : tb_ff_bank_ctrl
// Summary  : Directed vector bench for ff_bank_ctrl (WIDTH=4, DEPTH=8, DIV_W=3).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ff_bank_ctrl;

`ifdef FF_BANK_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       reset;
  logic       mode;
  logic       btn_step;
  logic       btn_run;
  logic [3:0] sw_j;
  logic [3:0] sw_k;
  logic [3:0] q;
  logic [2:0] step_idx;
  logic       running;
  logic       tick;

  int errors;
  int checks;

  ff_bank_ctrl #(.WIDTH(4), .DEPTH(8), .DIV_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .btn_step (btn_step),
    .btn_run  (btn_run),
    .sw_j     (sw_j),
    .sw_k     (sw_k),
    .q        (q),
    .step_idx (step_idx),
    .running  (running),
    .tick     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] exp_q;
  } man_vec_t;

  typedef struct {
    logic [3:0] exp_q;
    logic [2:0] exp_idx;
  } tick_vec_t;

  man_vec_t  man_tbl[5];
  tick_vec_t tick_tbl[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_tick: got no tick expected tick within 20 cycles");
    end
  endtask

  initial begin
    int n;
    errors = 0;
    checks = 0;

    // manual vectors applied in order, starting from q=1011
    man_tbl[0] = '{4'b0000, 4'b0000, 4'b1011};
    man_tbl[1] = '{4'b1111, 4'b1111, 4'b0100};
    man_tbl[2] = '{4'b0000, 4'b1111, 4'b0000};
    man_tbl[3] = '{4'b0101, 4'b0000, 4'b0101};
    man_tbl[4] = '{4'b1010, 4'b0011, 4'b1110};

    // pattern steps 0..7 starting from q=0000
    tick_tbl[0] = '{4'b1100, 3'd1};
    tick_tbl[1] = '{4'b1010, 3'd2};
    tick_tbl[2] = '{4'b0001, 3'd3};
    tick_tbl[3] = '{4'b1000, 3'd4};
    tick_tbl[4] = '{4'b0100, 3'd5};
    tick_tbl[5] = '{4'b0010, 3'd6};
    tick_tbl[6] = '{4'b0001, 3'd7};
    tick_tbl[7] = '{4'b1000, 3'd0};

    reset = 1'b1; mode = 1'b0; btn_step = 1'b0; btn_run = 1'b0;
    sw_j = 4'b0000; sw_k = 4'b0000;
    step(); step();
    chk("reset_q", q, 4'b0000);
    chk("reset_idx", step_idx, 3'd0);
    chk("reset_running", running, 1'b0);
    chk("reset_tick", tick, 1'b0);
    reset = 1'b0;

    // held button yields exactly one apply
    sw_j = 4'b1011; sw_k = 4'b0110; btn_step = 1'b1;
    repeat (LAT) step();
    chk("manual_before", q, 4'b0000);
    step();
    chk("manual_apply", q, 4'b1011);
    repeat (3) step();
    btn_step = 1'b0;
    repeat (4) step();
    chk("manual_held_once", q, 4'b1011);

    for (int i = 0; i < 5; i++) begin
      sw_j = man_tbl[i].j; sw_k = man_tbl[i].k;
      btn_step = 1'b1;
      step();
      btn_step = 1'b0;
      repeat (LAT + 1) step();
      chk($sformatf("manual_vec%0d", i), q, man_tbl[i].exp_q);
    end

    // auto mode from a clean reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    mode = 1'b1; btn_run = 1'b1;
    step();
    btn_run = 1'b0;
    repeat (LAT) step();
    chk("run_enter", running, 1'b1);
    chk("run_q_start", q, 4'b0000);

    for (int i = 0; i < 8; i++) begin
      wait_tick();
      step();
      chk($sformatf("tick%0d_q", i), q, tick_tbl[i].exp_q);
      chk($sformatf("tick%0d_idx", i), step_idx, tick_tbl[i].exp_idx);
    end

    // btn_run rise lands in the same cycle as the next tick
    repeat (7 - LAT) step();
    btn_run = 1'b1;
    step();
    btn_run = 1'b0;
    repeat (LAT - 1) step();
    chk("coincide_tick", tick, 1'b1);
    step();
    chk("coincide_q", q, 4'b0100);
    chk("coincide_idx", step_idx, 3'd1);
    chk("coincide_paused", running, 1'b0);

    btn_step = 1'b1;
    step();
    btn_step = 1'b0;
    repeat (LAT + 1) step();
    chk("pause_step_q", q, 4'b0010);
    chk("pause_step_idx", step_idx, 3'd2);
    repeat (20) step();
    chk("pause_hold_q", q, 4'b0010);
    chk("pause_hold_idx", step_idx, 3'd2);
    chk("pause_hold_running", running, 1'b0);

    // simultaneous run and step rises in PAUSE: resume only
    btn_run = 1'b1; btn_step = 1'b1;
    step();
    btn_run = 1'b0; btn_step = 1'b0;
    repeat (LAT) step();
    chk("resume_running", running, 1'b1);
    chk("resume_q", q, 4'b0010);
    chk("resume_idx", step_idx, 3'd2);
    wait_tick();
    chk("resume_q_at_tick", q, 4'b0010);
    step();
    chk("resume_tick_q", q, 4'b0001);
    chk("resume_tick_idx", step_idx, 3'd3);

    wait_tick();
    step();
    chk("run_s3_q", q, 4'b1000);
    chk("run_s3_idx", step_idx, 3'd4);
    wait_tick();
    step();
    chk("run_s4_q", q, 4'b0100);
    chk("run_s4_idx", step_idx, 3'd5);

    // drop mode with step_idx=5
    mode = 1'b0;
    repeat (LAT) step();
    chk("idle_running", running, 1'b0);
    chk("idle_idx", step_idx, 3'd0);
    chk("idle_q", q, 4'b0100);

    // reset while running
    mode = 1'b1; btn_run = 1'b1;
    step();
    btn_run = 1'b0;
    repeat (LAT) step();
    chk("rerun_running", running, 1'b1);
    reset = 1'b1;
    step();
    chk("midreset_q", q, 4'b0000);
    chk("midreset_running", running, 1'b0);
    chk("midreset_idx", step_idx, 3'd0);
    chk("midreset_tick", tick, 1'b0);
    reset = 1'b0;
    n = 0;
    while (tick !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("first_tick_delay", n, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
